// File: rtl/reg_file_wr_responder_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the integer register file and every unit that writes
// into it (core writeback, integer divider, other multi-cycle units).
//   DATA_WIDTH / NUM_REGS / REG_SEL_WIDTH : register file geometry
//   t_reg_sel / t_data                    : selector and data word types
//   clog2_min1()                          : index width that never collapses to 0
// ---------------------------------------------------------------------------
package reg_file_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int NUM_REGS      = 32;
    localparam int REG_SEL_WIDTH = $clog2(NUM_REGS);
    localparam int NUM_CLIENTS   = 4;

    typedef logic [REG_SEL_WIDTH-1:0] t_reg_sel;
    typedef logic [DATA_WIDTH-1:0]    t_data;

    // A single-client arbiter still needs a 1-bit pointer/index.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_file_wr_responder_if.sv
// ---------------------------------------------------------------------------
// reg_file_wr_responder_if
// Bundles the register-file write handshake and the two read ports.
//   wr_req  [num_clients]                : per-client write request
//   wr_sel  [num_clients*reg_sel_width]  : packed selectors, client i = slice i
//   wr_data [num_clients*data_width]     : packed data, client i = slice i
//   wr_ack  [num_clients]                : one-cycle registered ack
//   rd_sel0/rd_data0, rd_sel1/rd_data1   : combinational read ports
//
// Handshake: a client raises wr_req[i] with wr_sel/wr_data stable and holds
// all three until it samples wr_ack[i]=1 on a rising edge; it then drops
// wr_req[i] (or presents a new request) at the following edge. The responder
// ignores wr_req[i] while wr_ack[i] is high, so a request held through its
// ack cycle is never written twice. Data is sampled only at the grant edge.
//
// master: the initiator side (clients + read-port user)
// slave : the responder (register file)
// ---------------------------------------------------------------------------
interface reg_file_wr_responder_if #(
    parameter int num_clients   = 4,
    parameter int reg_sel_width = 5,
    parameter int data_width    = 32
);

    logic [num_clients-1:0]               wr_req;
    logic [num_clients*reg_sel_width-1:0] wr_sel;
    logic [num_clients*data_width-1:0]    wr_data;
    logic [num_clients-1:0]               wr_ack;

    logic [reg_sel_width-1:0]             rd_sel0;
    logic [data_width-1:0]                rd_data0;
    logic [reg_sel_width-1:0]             rd_sel1;
    logic [data_width-1:0]                rd_data1;

    modport master (
        output wr_req, wr_sel, wr_data, rd_sel0, rd_sel1,
        input  wr_ack, rd_data0, rd_data1
    );

    modport slave (
        input  wr_req, wr_sel, wr_data, rd_sel0, rd_sel1,
        output wr_ack, rd_data0, rd_data1
    );

endinterface

// File: rtl/reg_file_wr_responder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with an internal pointer. Grants the first eligible
// client at or after the pointer (wrapping); after a grant the pointer moves
// to the client just past the winner, so the winner has lowest priority next.
//   clk, rst    : clock, asynchronous active-low reset (pointer -> 0)
//   eligible    : per-client eligibility vector
//   grant_valid : some client is granted this cycle
//   grant_idx   : index of the granted client (valid with grant_valid)
// ---------------------------------------------------------------------------
module rr_arbiter
    import reg_file_pkg::*;
#(
    parameter int num_clients      = 4,
    parameter int client_idx_width = clog2_min1(num_clients)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [num_clients-1:0]      eligible,
    output logic                        grant_valid,
    output logic [client_idx_width-1:0] grant_idx
);

    logic [client_idx_width-1:0] ptr;

    // Scan from the farthest offset down to offset 0 so the closest eligible
    // client to the pointer is the last (winning) assignment.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = num_clients - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= num_clients) idx = idx - num_clients;
            if (eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = client_idx_width'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (grant_valid) begin
            if (int'(grant_idx) == num_clients - 1) ptr <= '0;
            else                                    ptr <= grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_wr_responder.sv
// ---------------------------------------------------------------------------
// reg_file_wr_responder
// Integer register file and responder end of the register-file write
// handshake. Up to num_clients initiators request writes; a round-robin
// arbiter picks one per clock, the write lands at that edge and the winner
// gets a one-cycle registered ack. Register 0 reads as zero and is never
// written; selectors >= num_regs are acked without a write.
//   clk  : clock
//   rst  : asynchronous active-low reset (regs, acks, pointer cleared)
//   bus  : write handshake + two combinational read ports (slave side)
// ---------------------------------------------------------------------------
module reg_file_wr_responder
    import reg_file_pkg::*;
#(
    parameter int data_width  = DATA_WIDTH,
    parameter int num_regs    = NUM_REGS,
    parameter int num_clients = NUM_CLIENTS
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_file_wr_responder_if.slave bus
);

    localparam int reg_sel_width    = $clog2(num_regs);
    localparam int client_idx_width = clog2_min1(num_clients);

    logic [data_width-1:0]       regs [num_regs];
    logic [num_clients-1:0]      eligible;
    logic [num_clients-1:0]      ack_q;
    logic [num_clients-1:0]      ack_d;
    logic                        grant_valid;
    logic [client_idx_width-1:0] grant_idx;
    logic [reg_sel_width-1:0]    g_sel;
    logic [data_width-1:0]       g_data;
    logic                        do_write;
    logic [data_width-1:0]       rd_data0_c;
    logic [data_width-1:0]       rd_data1_c;

    // The ack term masks the cycle in which the winner still holds its request.
    assign eligible = bus.wr_req & ~ack_q;

    rr_arbiter #(
        .num_clients      (num_clients),
        .client_idx_width (client_idx_width)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .eligible    (eligible),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        g_sel    = bus.wr_sel[grant_idx*reg_sel_width +: reg_sel_width];
        g_data   = bus.wr_data[grant_idx*data_width +: data_width];
        do_write = grant_valid && (g_sel != '0) && (int'(g_sel) < num_regs);
        ack_d    = '0;
        if (grant_valid) ack_d[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q <= '0;
        end else begin
            ack_q <= ack_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < num_regs; i++) regs[i] <= '0;
        end else if (do_write) begin
            regs[g_sel] <= g_data;
        end
    end

    // No bypass: a write at an edge shows up on the read ports after it.
    always_comb begin
        rd_data0_c = '0;
        rd_data1_c = '0;
        if ((bus.rd_sel0 != '0) && (int'(bus.rd_sel0) < num_regs)) rd_data0_c = regs[bus.rd_sel0];
        if ((bus.rd_sel1 != '0) && (int'(bus.rd_sel1) < num_regs)) rd_data1_c = regs[bus.rd_sel1];
    end

    assign bus.wr_ack   = ack_q;
    assign bus.rd_data0 = rd_data0_c;
    assign bus.rd_data1 = rd_data1_c;

endmodule

// File: doc/reg_file_wr_responder.md
Name: reg_file_wr_responder

Overview:
- Responder end of the register-file write handshake (rf_wr_sel / rf_wr_data / rf_wr_req / rf_wr_ack) used by multi-cycle units such as the integer divider.
- Owns the integer register file.
- Accepts write requests from up to num_clients initiators, arbitrates round-robin, performs one write per clock, and returns a one-cycle ack to the winning client.
- Also provides two combinational read ports for the core.

Parameters:
- data_width, 32, bits per register.
- num_regs, 32, number of registers; register 0 is hardwired to zero.
- num_clients, 4, number of write initiators; client 0 is the core's writeback.
- reg_sel_width, $clog2(num_regs), register selector width (derived).
- client_idx_width, $clog2(num_clients) (minimum 1), arbiter pointer width (derived).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- wr_req  in  num_clients  per-client write request; held high until that client sees its ack.
- wr_sel  in  num_clients*reg_sel_width  packed selectors; client i uses slice i.
- wr_data  in  num_clients*data_width  packed write data; client i uses slice i.
- wr_ack  out  num_clients  registered per-client ack, one-cycle pulse.
- rd_sel0  in  reg_sel_width  read port 0 selector.
- rd_data0  out  data_width  read port 0 data, combinational.
- rd_sel1  in  reg_sel_width  read port 1 selector.
- rd_data1  out  data_width  read port 1 data, combinational.

Behaviour:
- Reset (rst low, asynchronous):
  - All registers cleared to 0, wr_ack = 0, round-robin pointer = 0.
  - Requests pending at reset are dropped silently. A client still holding wr_req after rst releases is served normally.
- Eligibility:
  - Client i is eligible at an edge iff wr_req[i]=1 and wr_ack[i]=0.
  - The wr_ack[i]=0 term masks the ack cycle, during which the client still holds req and drops it at the following edge. The same request is never written twice.
- Arbitration:
  - Among eligible clients, grant the first at or after pointer p, wrapping modulo num_clients.
  - At most one grant per edge.
- Grant at edge E to client g:
  - regs[wr_sel[g]] <= wr_data[g], unless wr_sel[g]==0, in which case there is no write but g is still acked.
  - wr_ack[g] <= 1; all other wr_ack bits <= 0.
  - p <= g+1, wrapping num_clients-1 -> 0.
- No eligible client: wr_ack <= 0, p unchanged, no write.
- Latency: request present before edge E gets data written and ack high in the cycle after E, provided no contention. Worst case is num_clients edges with all clients requesting continuously.
- Ack is high for exactly one cycle per accepted request. The same client cannot be acked on consecutive cycles.
- Reads:
  - rd_dataN = regs[rd_selN]; rd_selN==0 always returns 0.
  - No write-to-read bypass: a write at edge E is visible on read ports in the cycle after E.
- Same selector from two clients: each is written in its own grant cycle; the later grant wins.
- Selector >= num_regs (non-power-of-2 num_regs): no write, client still acked.
- wr_sel/wr_data of a requesting client must be stable from req rise until ack; values are sampled only at the grant edge.

Decomposition:
- Shared package reg_file_pkg holds:
  - DATA_WIDTH, NUM_REGS, REG_SEL_WIDTH constants.
  - typedef logic [REG_SEL_WIDTH-1:0] t_reg_sel; typedef logic [DATA_WIDTH-1:0] t_data.
  - The divider and other multi-cycle units import the same package.
- One sub-module: rr_arbiter.
  - Parameter num_clients.
  - Inputs: eligible vector, clk, rst.
  - Outputs: grant_valid, grant_idx.
  - Owns the pointer register.
- The register array and ack logic stay in the top module.

Test Plan:
- Reset then read: hold rst low mid-stream with wr_req[1]=1. Required: rd_data0/1 = 0 for all selectors, wr_ack = 0. After release, client 1 is acked within 1 cycle.
- Single write: client 2 req sel=5 data=0xDEADBEEF at edge E. Required:
  - wr_ack[2]=1 for exactly one cycle after E.
  - rd_sel0=5 returns 0xDEADBEEF in that cycle.
  - Client holds req through the ack cycle; there is no second ack.
- x0 write: client 0 sel=0 data=0x1234. Required: acked once; rd_data for sel 0 remains 0.
- Contention: clients 0, 1, 3 request simultaneously (sel 1, 2, 3; data 0x11, 0x22, 0x33) with p=0. Required: acks in order 0, 1, 3 on successive cycles; final regs 1, 2, 3 = 0x11, 0x22, 0x33.
- Fairness: client 0 re-requests immediately after each ack while client 1 requests continuously. Required: grants alternate 0, 1, 0, 1; neither waits more than num_clients cycles.
- Divider pairing: int_div-style client writes quotient (sel 7) then modulus (sel 8) for 100/7. Required: reg7=14, reg8=2, each acked exactly once.
